// File: rtl/fifo_word_packer.sv
// Packs WORDS consecutive FIFO reads into one wide word per req edge.
// Handles empty-FIFO stalls, abort, and drops requests that arrive while busy.
module fifo_word_packer #(
  parameter int IN_W      = 32,
  parameter int WORDS     = 3,
  parameter int MSB_FIRST = 1,
  parameter int EDGE_SEL  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  abort,
  output logic                  fifo_rd,
  input  logic                  fifo_empty,
  input  logic [IN_W-1:0]       fifo_dout,
  output logic [IN_W*WORDS-1:0] out_data,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  req_drop
);

  localparam int CW = $clog2(WORDS + 1);
  localparam int OW = IN_W * WORDS;
  localparam logic [CW-1:0] WORDS_C = CW'(WORDS);
  localparam logic [CW-1:0] LAST_C  = CW'(WORDS - 1);
  localparam logic          SYNC_RST = (EDGE_SEL != 0);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          r0;
  logic          r1;
  logic          trig;
  logic          rd_q;
  logic          cap;
  logic          last_cap;
  logic          kill;
  logic [CW-1:0] issued;
  logic [CW-1:0] rcvd;
  logic [OW-1:0] acc;
  logic [OW-1:0] acc_nx;

  assign trig = (EDGE_SEL != 0) ? (r0 & ~r1) : (r1 & ~r0);

  // Accumulator with the word arriving this cycle dropped into slot rcvd
  always_comb begin
    acc_nx = acc;
    for (int k = 0; k < WORDS; k++) begin
      if (rcvd == CW'(k)) begin
        if (MSB_FIRST != 0)
          acc_nx[IN_W*(WORDS-k)-1 -: IN_W] = fifo_dout;
        else
          acc_nx[IN_W*k +: IN_W] = fifo_dout;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    fifo_rd   = 1'b0;
    out_valid = 1'b0;
    cap       = 1'b0;
    last_cap  = 1'b0;
    busy      = (state != IDLE);
    kill      = abort & busy;
    req_drop  = trig & busy;
    unique case (state)
      IDLE: begin
        if (trig)
          state_nx = READ;
      end
      READ: begin
        fifo_rd  = (issued < WORDS_C)
                 & ~fifo_empty & ~abort;
        cap      = rd_q & ~abort;
        last_cap = cap & (rcvd == LAST_C);
        if (last_cap)
          state_nx = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (kill)
      state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      r0       <= SYNC_RST;
      r1       <= SYNC_RST;
      rd_q     <= 1'b0;
      issued   <= '0;
      rcvd     <= '0;
      acc      <= '0;
      out_data <= '0;
    end else begin
      r0    <= req;
      r1    <= r0;
      state <= state_nx;
      rd_q  <= fifo_rd;
      if (kill || state == DONE) begin
        issued <= '0;
        rcvd   <= '0;
      end else begin
        if (fifo_rd)
          issued <= issued + 1'b1;
        if (cap) begin
          rcvd <= rcvd + 1'b1;
          acc  <= acc_nx;
        end
      end
      // Full word becomes visible only on the last capture
      if (last_cap)
        out_data <= acc_nx;
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: three parameter sets,
// FIFO models with 1-cycle read latency, directed packing scenarios.
module tb_fifo_word_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // DUT A: 32x3, MSB first, falling edge
  logic        req_a = 0, abort_a = 0, rd_a, empty_a;
  logic        busy_a, drop_a, ov_a, stall_a = 0;
  logic [31:0] dout_a = '0;
  logic [95:0] out_a;
  // DUT B: 32x3, LSB first, falling edge
  logic        req_b = 0, abort_b = 0, rd_b, empty_b;
  logic        busy_b, drop_b, ov_b;
  logic [31:0] dout_b = '0;
  logic [95:0] out_b;
  // DUT C: 16x8, MSB first, rising edge
  logic         req_c = 1, abort_c = 0, rd_c, empty_c;
  logic         busy_c, drop_c, ov_c;
  logic [15:0]  dout_c = '0;
  logic [127:0] out_c;

  fifo_word_packer #(.IN_W(32), .WORDS(3),
    .MSB_FIRST(1), .EDGE_SEL(0)) u_a (
    .clk(clk), .rst_n(rst_n), .req(req_a),
    .abort(abort_a), .fifo_rd(rd_a),
    .fifo_empty(empty_a), .fifo_dout(dout_a),
    .out_data(out_a), .out_valid(ov_a),
    .busy(busy_a), .req_drop(drop_a));

  fifo_word_packer #(.IN_W(32), .WORDS(3),
    .MSB_FIRST(0), .EDGE_SEL(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req(req_b),
    .abort(abort_b), .fifo_rd(rd_b),
    .fifo_empty(empty_b), .fifo_dout(dout_b),
    .out_data(out_b), .out_valid(ov_b),
    .busy(busy_b), .req_drop(drop_b));

  fifo_word_packer #(.IN_W(16), .WORDS(8),
    .MSB_FIRST(1), .EDGE_SEL(1)) u_c (
    .clk(clk), .rst_n(rst_n), .req(req_c),
    .abort(abort_c), .fifo_rd(rd_c),
    .fifo_empty(empty_c), .fifo_dout(dout_c),
    .out_data(out_c), .out_valid(ov_c),
    .busy(busy_c), .req_drop(drop_c));

  // FIFO models: rd sampled mid-cycle, data and empty updated at the edge
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  logic [15:0] qc[$];
  logic rs_a = 0, rs_b = 0, rs_c = 0;
  logic er_a = 1, er_b = 1, er_c = 1;

  assign empty_a = er_a | stall_a;
  assign empty_b = er_b;
  assign empty_c = er_c;

  always @(negedge clk) begin
    rs_a <= rd_a;
    rs_b <= rd_b;
    rs_c <= rd_c;
  end

  always @(posedge clk) begin
    if (rs_a && qa.size() > 0) dout_a <= qa.pop_front();
    if (rs_b && qb.size() > 0) dout_b <= qb.pop_front();
    if (rs_c && qc.size() > 0) dout_c <= qc.pop_front();
    er_a <= (qa.size() == 0);
    er_b <= (qb.size() == 0);
    er_c <= (qc.size() == 0);
  end

  // Scoreboard queues and monitors
  logic [127:0] exp_a[$];
  logic [127:0] exp_b[$];
  logic [127:0] exp_c[$];
  int rdh_a[$];
  int ovh_a[$];
  int rdh_b[$];
  int ovh_b[$];
  int rdh_c[$];
  int ovh_c[$];
  int drops_a = 0;

  always @(negedge clk) begin
    logic [127:0] e;
    if (rd_a) rdh_a.push_back(cyc);
    if (drop_a) drops_a++;
    if (ov_a) begin
      ovh_a.push_back(cyc);
      if (exp_a.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_valid: got %0h expected none",
                 out_a);
      end else begin
        e = exp_a.pop_front();
        chk("a_out_data", {32'h0, out_a}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [127:0] e;
    if (rd_b) rdh_b.push_back(cyc);
    if (ov_b) begin
      ovh_b.push_back(cyc);
      if (exp_b.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL b_unexpected_valid: got %0h expected none",
                 out_b);
      end else begin
        e = exp_b.pop_front();
        chk("b_out_data", {32'h0, out_b}, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [127:0] e;
    if (rd_c) rdh_c.push_back(cyc);
    if (ov_c) begin
      ovh_c.push_back(cyc);
      if (exp_c.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL c_unexpected_valid: got %0h expected none",
                 out_c);
      end else begin
        e = exp_c.pop_front();
        chk("c_out_data", out_c, e);
      end
    end
  end

  function automatic int ov_cnt(input int s);
    case (s)
      0:       return ovh_a.size();
      1:       return ovh_b.size();
      default: return ovh_c.size();
    endcase
  endfunction

  task automatic wait_ov(input int s, input int target,
                         input string nm);
    int n;
    n = 0;
    while (ov_cnt(s) < target && n < 80) begin
      tick(1);
      n++;
    end
    chk(nm, ov_cnt(s), target);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0i;
    int o0;
    int d0;
    int n;
    logic [127:0] prev;

    // Reset values
    tick(2);
    @(negedge clk);
    chk("rst_out_data", {32'h0, out_a}, 0);
    chk("rst_ctrl", {ov_a, rd_a, busy_a, drop_a}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // req_c held high through reset release: no trigger
    tick(6);
    @(negedge clk);
    chk("c_no_spurious_busy", busy_c, 0);
    chk("c_no_spurious_rd", rdh_c.size(), 0);
    tick(1);

    // Test 1: MSB first, back-to-back reads, t+2 latency
    qa.push_back(32'hA);
    qa.push_back(32'hB);
    qa.push_back(32'hC);
    tick(1);
    r0i = rdh_a.size();
    o0  = ovh_a.size();
    exp_a.push_back(128'h0000000A_0000000B_0000000C);
    req_a = 1;
    tick(2);
    req_a = 0;
    wait_ov(0, o0 + 1, "t1_valid");
    chk("t1_rd_count", rdh_a.size() - r0i, 3);
    if (rdh_a.size() >= r0i + 3 && ovh_a.size() > o0) begin
      chk("t1_rd_span", rdh_a[r0i+2] - rdh_a[r0i], 2);
      chk("t1_latency", ovh_a[o0] - rdh_a[r0i+2], 2);
    end
    tick(3);

    // Test 2: LSB first
    qb.push_back(32'hA);
    qb.push_back(32'hB);
    qb.push_back(32'hC);
    tick(1);
    exp_b.push_back(128'h0000000C_0000000B_0000000A);
    req_b = 1;
    tick(2);
    req_b = 0;
    wait_ov(1, 1, "t2_valid");
    chk("t2_rd_count", rdh_b.size(), 3);
    tick(3);

    // Test 3: 4-cycle empty stall after the first read
    qa.push_back(32'hD);
    qa.push_back(32'hE);
    qa.push_back(32'hF);
    tick(1);
    r0i = rdh_a.size();
    o0  = ovh_a.size();
    exp_a.push_back(128'h0000000D_0000000E_0000000F);
    req_a = 1;
    tick(2);
    req_a = 0;
    n = 0;
    @(negedge clk);
    while (!rd_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 stall_a = 1;
    repeat (4) @(posedge clk);
    #1 stall_a = 0;
    wait_ov(0, o0 + 1, "t3_valid");
    tick(3);
    chk("t3_valid_once", ovh_a.size() - o0, 1);
    chk("t3_rd_count", rdh_a.size() - r0i, 3);
    if (rdh_a.size() >= r0i + 3) begin
      chk("t3_gap", rdh_a[r0i+1] - rdh_a[r0i], 5);
      chk("t3_resume", rdh_a[r0i+2] - rdh_a[r0i+1], 1);
    end

    // Test 4: second falling edge while busy
    qa.push_back(32'h1);
    qa.push_back(32'h2);
    qa.push_back(32'h3);
    tick(1);
    o0 = ovh_a.size();
    d0 = drops_a;
    exp_a.push_back(128'h00000001_00000002_00000003);
    req_a = 1;
    tick(2);
    req_a = 0;
    n = 0;
    @(negedge clk);
    while (!busy_a && n < 40) begin
      @(negedge clk);
      n++;
    end
    tick(1);
    req_a = 1;
    tick(1);
    req_a = 0;
    wait_ov(0, o0 + 1, "t4_valid");
    tick(4);
    chk("t4_drop_once", drops_a - d0, 1);
    chk("t4_valid_once", ovh_a.size() - o0, 1);
    chk("t4_idle", busy_a, 0);

    // Test 5: abort after two captures, then a fresh request
    prev = 128'h00000001_00000002_00000003;
    qa.push_back(32'h11);
    qa.push_back(32'h22);
    tick(1);
    o0 = ovh_a.size();
    req_a = 1;
    tick(2);
    req_a = 0;
    n = 0;
    d0 = 0;
    while (d0 < 2 && n < 40) begin
      @(negedge clk);
      if (rd_a) d0++;
      n++;
    end
    repeat (2) @(posedge clk);
    #1 abort_a = 1;
    @(posedge clk);
    #1 abort_a = 0;
    @(negedge clk);
    chk("t5_abort_idle", busy_a, 0);
    chk("t5_out_kept", {32'h0, out_a}, prev);
    tick(4);
    chk("t5_no_valid", ovh_a.size() - o0, 0);
    qa.push_back(32'h7);
    qa.push_back(32'h8);
    qa.push_back(32'h9);
    tick(1);
    r0i = rdh_a.size();
    exp_a.push_back(128'h00000007_00000008_00000009);
    req_a = 1;
    tick(2);
    req_a = 0;
    wait_ov(0, o0 + 1, "t5_valid");
    chk("t5_rd_count", rdh_a.size() - r0i, 3);
    tick(3);

    // Test 6: rising-edge trigger, 8x16 pack
    for (int i = 1; i <= 8; i++)
      qc.push_back(16'(i * 16'h1111));
    tick(1);
    exp_c.push_back(
      128'h1111_2222_3333_4444_5555_6666_7777_8888);
    req_c = 0;
    tick(2);
    req_c = 1;
    wait_ov(2, 1, "t6_valid");
    chk("t6_rd_count", rdh_c.size(), 8);
    if (rdh_c.size() >= 8)
      chk("t6_rd_span", rdh_c[7] - rdh_c[0], 7);

    tick(5);
    chk("sb_a_drained", exp_a.size(), 0);
    chk("sb_b_drained", exp_b.size(), 0);
    chk("sb_c_drained", exp_c.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
